dmux_pipeline_hs: RTL and testbench

// - Handshaked, fixed-depth pipelined demultiplexer: routes one WIDTH-bit input beat to one of OUTPUT_COUNT outputs.
// - Successor to the free-running LFMR dmux. Adds valid/ready flow control per output, sel carried with data,
//   out-of-range sel detection, a selectable idle-output mode, and a per-output beat counter.
// - Sits between a single producer and OUTPUT_COUNT independent consumers (stream fan-out).

---
 rtl/dmux_pipeline_hs_pkg.sv | 17 +
 rtl/dmux_hs_stage.sv | 44 ++++
 rtl/dmux_pipeline_hs.sv | 130 +++++++++++++
 tb/tb_dmux_pipeline_hs.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pipeline_hs_pkg.sv
// rtl/dmux_pipeline_hs_pkg.sv - shared sizing helpers for the handshaked pipelined demux
// Stage records are {v, sel, data}; channel c of a flat bus sits at [c*w +: w].
package dmux_pipeline_hs_pkg;

  function automatic int f_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int f_rec_width(input int sel_w, input int width);
    return 1 + sel_w + width;
  endfunction

endpackage

`ifndef DMUX_CH
`define DMUX_CH(c, w) ((c)*(w)) +: (w)
`endif

// File: rtl/dmux_hs_stage.sv
// rtl/dmux_hs_stage.sv - one {v,sel,data} pipeline register with ready-chain logic
// Accepts when empty or when the downstream side takes the held beat this cycle.
module dmux_hs_stage
  import dmux_pipeline_hs_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [SEL_W-1:0] up_sel,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [SEL_W-1:0] dn_sel,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);

  localparam int REC_W = f_rec_width(SEL_W, WIDTH);

  logic [REC_W-1:0] rec_q;
  logic [REC_W-1:0] rec_d;

  assign up_ready = ~rec_q[REC_W-1] | dn_ready;

  // Payload bits are left untouched when the stage empties; only v clears.
  always_comb begin
    rec_d = rec_q;
    if (up_ready) begin
      if (up_valid) rec_d = {1'b1, up_sel, up_data};
      else          rec_d[REC_W-1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rec_q <= '0;
    else        rec_q <= rec_d;
  end

  assign {dn_valid, dn_sel, dn_data} = rec_q;

endmodule

// File: rtl/dmux_pipeline_hs.sv
// rtl/dmux_pipeline_hs.sv - handshaked fixed-depth pipelined demultiplexer top
// Single in-order pipe feeds output decode, idle-data handling and per-channel beat counters.
module dmux_pipeline_hs
  import dmux_pipeline_hs_pkg::*;
#(
  parameter int  WIDTH        = 8,
  parameter int  OUTPUT_COUNT = 4,
  parameter int  LATENCY      = 2,
  parameter int  IDLE_ZERO    = 1,
  parameter int  CNT_WIDTH    = 16,
  localparam int SEL_W        = f_sel_width(OUTPUT_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SEL_W-1:0]                  in_sel,
  input  logic [WIDTH-1:0]                  in_data,
  output logic [OUTPUT_COUNT-1:0]           out_valid,
  input  logic [OUTPUT_COUNT-1:0]           out_ready,
  output logic [WIDTH*OUTPUT_COUNT-1:0]     out_data,
  output logic                              sel_err,
  output logic [CNT_WIDTH*OUTPUT_COUNT-1:0] beat_cnt
);

  logic             rdy_en_q;
  logic             sel_ok;
  logic             head_valid;
  logic             head_ready;
  logic             tail_valid;
  logic [SEL_W-1:0] tail_sel;
  logic [WIDTH-1:0] tail_data;
  logic             tail_sel_ready;

  // Keeps in_ready low while in reset and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign sel_ok     = int'(in_sel) < OUTPUT_COUNT;
  assign head_valid = rdy_en_q & in_valid & sel_ok;
  assign in_ready   = rdy_en_q & head_ready;
  assign sel_err    = in_valid & in_ready & ~sel_ok;

  always_comb begin
    tail_sel_ready = 1'b0;
    for (int c = 0; c < OUTPUT_COUNT; c++) begin
      if (int'(tail_sel) == c) tail_sel_ready = out_ready[c];
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign tail_valid = head_valid;
      assign tail_sel   = in_sel;
      assign tail_data  = in_data;
      assign head_ready = ~sel_ok | tail_sel_ready;
    end else begin : g_pipe
      logic             v_c    [LATENCY+1];
      logic [SEL_W-1:0] sel_c  [LATENCY+1];
      logic [WIDTH-1:0] data_c [LATENCY+1];
      logic             rdy_c  [LATENCY+1];

      assign v_c[0]         = head_valid;
      assign sel_c[0]       = in_sel;
      assign data_c[0]      = in_data;
      assign head_ready     = rdy_c[0];
      assign rdy_c[LATENCY] = ~v_c[LATENCY] | tail_sel_ready;

      for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        dmux_hs_stage #(
          .SEL_W (SEL_W),
          .WIDTH (WIDTH)
        ) u_stage (
          .clk      (clk),
          .rst_n    (rst_n),
          .up_valid (v_c[k]),
          .up_sel   (sel_c[k]),
          .up_data  (data_c[k]),
          .up_ready (rdy_c[k]),
          .dn_valid (v_c[k+1]),
          .dn_sel   (sel_c[k+1]),
          .dn_data  (data_c[k+1]),
          .dn_ready (rdy_c[k+1])
        );
      end

      assign tail_valid = v_c[LATENCY];
      assign tail_sel   = sel_c[LATENCY];
      assign tail_data  = data_c[LATENCY];
    end
  endgenerate

  for (genvar c = 0; c < OUTPUT_COUNT; c++) begin : g_ch
    logic                 hit;
    logic                 xfer;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign hit          = tail_valid & (int'(tail_sel) == c);
    assign xfer         = hit & out_ready[c];
    assign out_valid[c] = hit;
    assign cnt_d        = xfer ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign beat_cnt[`DMUX_CH(c, CNT_WIDTH)] = cnt_q;

    if (IDLE_ZERO != 0) begin : g_zero
      assign out_data[`DMUX_CH(c, WIDTH)] = hit ? tail_data : '0;
    end else begin : g_hold
      logic [WIDTH-1:0] hold_q;
      logic [WIDTH-1:0] hold_d;

      assign hold_d = xfer ? tail_data : hold_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
      end

      assign out_data[`DMUX_CH(c, WIDTH)] = hit ? tail_data : hold_q;
    end
  end

endmodule

// File: tb/tb_dmux_pipeline_hs.sv
// tb/tb_dmux_pipeline_hs.sv - self-checking bench for dmux_pipeline_hs
module tb_dmux_pipeline_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic        a_in_valid, a_in_ready, a_sel_err;
    logic [1:0]  a_in_sel;
    logic [7:0]  a_in_data;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic [63:0] a_beat_cnt;

    logic        b_in_valid, b_in_ready, b_sel_err;
    logic [2:0]  b_in_sel;
    logic [7:0]  b_in_data;
    logic [4:0]  b_out_valid, b_out_ready;
    logic [39:0] b_out_data;
    logic [19:0] b_beat_cnt;

    logic        c_in_valid, c_in_ready, c_sel_err;
    logic [1:0]  c_in_sel;
    logic [7:0]  c_in_data;
    logic [3:0]  c_out_valid, c_out_ready;
    logic [31:0] c_out_data;
    logic [63:0] c_beat_cnt;

    dmux_pipeline_hs #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2), .IDLE_ZERO(1), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .sel_err(a_sel_err), .beat_cnt(a_beat_cnt));

    dmux_pipeline_hs #(.WIDTH(8), .OUTPUT_COUNT(5), .LATENCY(2), .IDLE_ZERO(0), .CNT_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .sel_err(b_sel_err), .beat_cnt(b_beat_cnt));

    dmux_pipeline_hs #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(0), .IDLE_ZERO(1), .CNT_WIDTH(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sel(c_in_sel),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .sel_err(c_sel_err), .beat_cnt(c_beat_cnt));

    task automatic idle_all();
        a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = 4'hF;
        b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = 5'h1F;
        c_in_valid = 1'b0; c_in_sel = '0; c_in_data = '0; c_out_ready = 4'hF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        idle_all();
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b exp=000", {a_in_ready, b_in_ready, c_in_ready});
        end
        n_cmp++;
        if ({a_out_valid, b_out_valid, c_out_valid, a_sel_err, b_sel_err, c_sel_err} !== '0) begin
            n_err++;
            $display("FAIL reset_valid_err got a=%h b=%h c=%h err=%b exp=0", a_out_valid, b_out_valid,
                     c_out_valid, {a_sel_err, b_sel_err, c_sel_err});
        end
        n_cmp++;
        if (a_out_data !== '0 || b_out_data !== '0 || c_out_data !== '0) begin
            n_err++;
            $display("FAIL reset_data got a=%h b=%h c=%h exp=0", a_out_data, b_out_data, c_out_data);
        end
        n_cmp++;
        if (a_beat_cnt !== '0 || b_beat_cnt !== '0 || c_beat_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_cnt got a=%h b=%h c=%h exp=0", a_beat_cnt, b_beat_cnt, c_beat_cnt);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL release_in_ready got=%b exp=11", {a_in_ready, b_in_ready});
        end
        next_cycle();
        a_out_ready = 4'h0;
        a_in_valid  = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h11;
        next_cycle();
        a_in_sel = 2'd2; a_in_data = 8'h22;
        next_cycle();
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        next_cycle();
        rst_n       = 1'b1;
        a_out_ready = 4'hF;
        seen        = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_out_valid !== 4'h0 || a_sel_err !== 1'b0) seen = 1'b1;
            next_cycle();
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_output got=%b exp=0", seen);
        end
        n_cmp++;
        if (a_beat_cnt !== '0) begin
            n_err++;
            $display("FAIL midreset_cnt got=%h exp=0", a_beat_cnt);
        end
    endtask

    task automatic test_throughput();
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        a_out_ready = 4'hF;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 4) begin
                a_in_valid = 1'b1; a_in_sel = 2'(cyc); a_in_data = 8'hA0 + 8'(cyc);
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 4) begin
                n_cmp++;
                if (a_in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL tput_in_ready cyc=%0d got=%b exp=1", cyc, a_in_ready);
                end
            end
            exp_v = '0;
            exp_d = '0;
            if (cyc >= 2 && cyc <= 5) begin
                exp_v = 4'(1 << (cyc - 2));
                exp_d[(cyc-2)*8 +: 8] = 8'hA0 + 8'(cyc - 2);
            end
            n_cmp++;
            if (a_out_valid !== exp_v || a_out_data !== exp_d) begin
                n_err++;
                $display("FAIL tput_out cyc=%0d got v=%h d=%h exp v=%h d=%h", cyc, a_out_valid, a_out_data, exp_v, exp_d);
            end
            next_cycle();
        end
        n_cmp++;
        if (a_beat_cnt !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
            n_err++;
            $display("FAIL tput_cnt got=%h exp=0001000100010001", a_beat_cnt);
        end
    endtask

    task automatic test_zero_latency();
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        c_out_ready = 4'hF;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                c_in_valid = 1'b1; c_in_sel = 2'(cyc); c_in_data = 8'hA0 + 8'(cyc);
            end else begin
                c_in_valid = 1'b0;
            end
            @(negedge clk);
            exp_v = '0;
            exp_d = '0;
            if (cyc < 4) begin
                exp_v = 4'(1 << cyc);
                exp_d[cyc*8 +: 8] = 8'hA0 + 8'(cyc);
                n_cmp++;
                if (c_in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL l0_in_ready cyc=%0d got=%b exp=1", cyc, c_in_ready);
                end
            end
            n_cmp++;
            if (c_out_valid !== exp_v || c_out_data !== exp_d) begin
                n_err++;
                $display("FAIL l0_out cyc=%0d got v=%h d=%h exp v=%h d=%h", cyc, c_out_valid, c_out_data, exp_v, exp_d);
            end
            next_cycle();
        end
        n_cmp++;
        if (c_beat_cnt !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
            n_err++;
            $display("FAIL l0_cnt got=%h exp=0001000100010001", c_beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  bsel [3] = '{2'd2, 2'd0, 2'd1};
        logic [7:0]  bdat [3] = '{8'hC2, 8'hC0, 8'hC1};
        logic [9:0]  got  [$];
        int          idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            a_out_ready = (cyc < 5) ? 4'b1011 : 4'hF;
            if (idx < 3) begin
                a_in_valid = 1'b1; a_in_sel = bsel[idx]; a_in_data = bdat[idx];
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                n_cmp++;
                if (a_out_valid !== 4'b0100 || a_out_data !== 32'h00C2_0000 || a_in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_stall cyc=%0d got v=%h d=%h rdy=%b exp v=4 d=00c20000 rdy=0",
                             cyc, a_out_valid, a_out_data, a_in_ready);
                end
            end
            if (a_in_valid && a_in_ready) idx++;
            for (int c = 0; c < 4; c++)
                if (a_out_valid[c] && a_out_ready[c]) got.push_back({2'(c), a_out_data[c*8 +: 8]});
            next_cycle();
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_err++;
            $display("FAIL bp_count got=%0d exp=3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== {bsel[i], bdat[i]}) begin
                n_err++;
                $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], {bsel[i], bdat[i]});
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [4:0] exp_v;
        b_out_ready = 5'h1F;
        for (int cyc = 0; cyc < 7; cyc++) begin
            b_in_valid = (cyc < 2);
            b_in_sel   = (cyc == 0) ? 3'd7 : 3'd4;
            b_in_data  = (cyc == 0) ? 8'h77 : 8'h44;
            @(negedge clk);
            n_cmp++;
            if (b_sel_err !== (cyc == 0)) begin
                n_err++;
                $display("FAIL oor_sel_err cyc=%0d got=%b exp=%b", cyc, b_sel_err, cyc == 0);
            end
            if (cyc < 2) begin
                n_cmp++;
                if (b_in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL oor_in_ready cyc=%0d got=%b exp=1", cyc, b_in_ready);
                end
            end
            exp_v = (cyc == 3) ? 5'b10000 : 5'b00000;
            n_cmp++;
            if (b_out_valid !== exp_v) begin
                n_err++;
                $display("FAIL oor_valid cyc=%0d got=%h exp=%h", cyc, b_out_valid, exp_v);
            end
            if (cyc == 3) begin
                n_cmp++;
                if (b_out_data[39:32] !== 8'h44) begin
                    n_err++;
                    $display("FAIL oor_data got=%h exp=44", b_out_data[39:32]);
                end
            end
            next_cycle();
        end
        n_cmp++;
        if (b_beat_cnt !== 20'h1_0000) begin
            n_err++;
            $display("FAIL oor_cnt got=%h exp=10000", b_beat_cnt);
        end
    endtask

    task automatic test_idle_mode();
        a_out_ready = 4'hF; b_out_ready = 5'h1F;
        for (int cyc = 0; cyc < 6; cyc++) begin
            a_in_valid = (cyc == 0); a_in_sel = 2'd1; a_in_data = 8'h5A;
            b_in_valid = (cyc == 0); b_in_sel = 3'd1; b_in_data = 8'h5A;
            @(negedge clk);
            if (cyc == 2) begin
                n_cmp++;
                if (a_out_valid !== 4'b0010 || b_out_valid !== 5'b00010) begin
                    n_err++;
                    $display("FAIL idle_deliver got a=%h b=%h exp a=2 b=2", a_out_valid, b_out_valid);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (b_out_valid !== 5'h0 || b_out_data !== 40'h44_0000_5A00) begin
            n_err++;
            $display("FAIL idle_hold got v=%h d=%h exp v=0 d=4400005a00", b_out_valid, b_out_data);
        end
        n_cmp++;
        if (a_out_valid !== 4'h0 || a_out_data !== 32'h0) begin
            n_err++;
            $display("FAIL idle_zero got v=%h d=%h exp v=0 d=0", a_out_valid, a_out_data);
        end
        next_cycle();
    endtask

    task automatic test_cnt_wrap();
        int sent = 0;
        b_out_ready = 5'h1F;
        for (int cyc = 0; cyc < 60 && sent < 17; cyc++) begin
            b_in_valid = 1'b1; b_in_sel = 3'd3; b_in_data = 8'(sent);
            @(negedge clk);
            if (b_in_ready) sent++;
            next_cycle();
        end
        b_in_valid = 1'b0;
        n_cmp++;
        if (sent != 17) begin
            n_err++;
            $display("FAIL wrap_sent got=%0d exp=17", sent);
        end
        repeat (4) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (b_beat_cnt !== 20'h1_1010) begin
            n_err++;
            $display("FAIL wrap_cnt got=%h exp=11010", b_beat_cnt);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [9:0]  q [$];
        int          cnt [4] = '{0, 0, 0, 0};
        logic        prev_stall [4] = '{0, 0, 0, 0};
        logic [7:0]  prev_data [4];
        logic        last_ready = 1'b1;
        logic        bad;
        rst_n = 1'b0;
        idle_all();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        for (int cyc = 0; cyc < 3006; cyc++) begin
            if (cyc >= 3000) begin
                a_in_valid = 1'b0; a_out_ready = 4'hF;
            end else begin
                if (!(a_in_valid && !last_ready)) begin
                    a_in_valid = ($urandom_range(0, 3) != 0);
                    a_in_sel   = 2'($urandom);
                    a_in_data  = 8'($urandom);
                end
                for (int c = 0; c < 4; c++) a_out_ready[c] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            bad = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (!a_out_valid[c] && a_out_data[c*8 +: 8] !== 8'h0) bad = 1'b1;
                if (prev_stall[c] && (!a_out_valid[c] || a_out_data[c*8 +: 8] !== prev_data[c])) bad = 1'b1;
            end
            n_cmp++;
            if (bad || $countones(a_out_valid) > 1 || a_sel_err !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_invariant cyc=%0d got v=%h d=%h err=%b", cyc, a_out_valid, a_out_data, a_sel_err);
            end
            n_cmp++;
            if (q.size() < 2 && a_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_ready_room cyc=%0d got=%b exp=1 occ=%0d", cyc, a_in_ready, q.size());
            end else if (q.size() == 2 && (a_in_ready !== a_out_ready[q[0][9:8]] || a_out_valid !== 4'(1 << q[0][9:8]))) begin
                n_err++;
                $display("FAIL rnd_full cyc=%0d got rdy=%b v=%h exp rdy=%b v=%h", cyc, a_in_ready, a_out_valid,
                         a_out_ready[q[0][9:8]], 4'(1 << q[0][9:8]));
            end
            if (a_out_valid != 0) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_spurious cyc=%0d got v=%h exp v=0", cyc, a_out_valid);
                end else if (a_out_valid !== 4'(1 << q[0][9:8]) || a_out_data[q[0][9:8]*8 +: 8] !== q[0][7:0]) begin
                    n_err++;
                    $display("FAIL rnd_order cyc=%0d got v=%h d=%h exp sel=%0d data=%h", cyc, a_out_valid,
                             a_out_data, q[0][9:8], q[0][7:0]);
                end
            end
            if (q.size() > 0 && a_out_valid[q[0][9:8]] && a_out_ready[q[0][9:8]]) begin
                cnt[q[0][9:8]]++;
                void'(q.pop_front());
            end
            if (a_in_valid && a_in_ready) q.push_back({a_in_sel, a_in_data});
            last_ready = a_in_ready;
            for (int c = 0; c < 4; c++) begin
                prev_stall[c] = a_out_valid[c] & ~a_out_ready[c];
                prev_data[c]  = a_out_data[c*8 +: 8];
            end
            next_cycle();
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL rnd_drain got=%0d left exp=0", q.size());
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (a_beat_cnt[c*16 +: 16] !== 16'(cnt[c])) begin
                n_err++;
                $display("FAIL rnd_cnt ch=%0d got=%0d exp=%0d", c, a_beat_cnt[c*16 +: 16], cnt[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_zero_latency();
        test_backpressure();
        test_out_of_range();
        test_idle_mode();
        test_cnt_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
